// File: rtl/mac_error_monitor_if.sv
// ---------------------------------------------------------------------------
// mac_error_monitor_if
//   Operand/result bus between the approximate MAC and its error monitor.
//   The master drives the operands as issued to the MAC and the MAC result.
//   The monitor observes the bus through the slave modport.
//
//   in_valid   operands issued to the MAC this cycle (sload & clken)
//   dataa      operand A, DW bits
//   datab      operand B, DW bits
//   adder_out  MAC result, 2*DW bits
// ---------------------------------------------------------------------------
interface mac_error_monitor_if #(
  parameter int DW = 8
);
  logic              in_valid;
  logic [DW-1:0]     dataa;
  logic [DW-1:0]     datab;
  logic [2*DW-1:0]   adder_out;

  modport master (output in_valid, dataa, datab, adder_out);
  modport slave  (input  in_valid, dataa, datab, adder_out);
endinterface

// File: rtl/mac_error_monitor.sv
// ---------------------------------------------------------------------------
// mac_error_monitor
//   In-line result checker for the approximate MAC. Each operand pair issued
//   while running is carried through a MAC_LAT-deep delay line; when it
//   emerges, the exact product is recomputed and compared against adder_out
//   in that same cycle. Sample, error and outlier counts plus the sum of
//   absolute errors are accumulated with saturation.
//
//   Optional feature macro: MAC_MON_MAXTRACK_EN
//     defined   -> largest |err| and the operands that first produced it
//     undefined -> max_err_o / max_a_o / max_b_o are tied to 0
//
// Ports
//   clk            rising-edge clock
//   aclr_n         synchronous active-low reset
//   start_i        pulse: clear stats and enter RUN
//   stop_i         pulse: enter DONE
//   clear_i        pulse: zero stats, FSM state unchanged
//   num_samples_i  auto-stop count, 0 = unlimited
//   mac            operand/result bus (slave modport)
//   busy_o         1 while in RUN
//   done_o         1 while in DONE
//   sample_cnt_o   samples compared
//   err_cnt_o      samples with approx != exact
//   outlier_cnt_o  samples with |err|*100 > exact*THR_PCT
//   err_sum_o      sum of |adder_out - exact|
//   max_err_o      largest |err| seen
//   max_a_o/max_b_o operands of the first sample reaching max_err_o
// ---------------------------------------------------------------------------
module mac_error_monitor #(
  parameter int DW      = 8,
  parameter int MAC_LAT = 2,
  parameter int THR_PCT = 5,
  parameter int CNT_W   = 16,
  parameter int SUM_W   = 32
) (
  input  logic                clk,
  input  logic                aclr_n,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                clear_i,
  input  logic [CNT_W-1:0]    num_samples_i,
  mac_error_monitor_if.slave  mac,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    sample_cnt_o,
  output logic [CNT_W-1:0]    err_cnt_o,
  output logic [CNT_W-1:0]    outlier_cnt_o,
  output logic [SUM_W-1:0]    err_sum_o,
  output logic [2*DW-1:0]     max_err_o,
  output logic [DW-1:0]       max_a_o,
  output logic [DW-1:0]       max_b_o
);

  localparam int PW = 2 * DW;                        // product width
  localparam int EW = PW + 1;                        // |err| width, no wrap
  localparam int OW = EW + 32;                       // outlier products
  localparam int AW = ((EW > SUM_W) ? EW : SUM_W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // -------------------------------------------------------------------------
  // Arithmetic helpers
  // -------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] s,
                                               input logic [EW-1:0]    e);
    logic [AW-1:0] t;
    t = AW'(s) + AW'(e);
    return (t > AW'({SUM_W{1'b1}})) ? {SUM_W{1'b1}} : t[SUM_W-1:0];
  endfunction

  function automatic logic [EW-1:0] abs_diff(input logic [PW-1:0] x,
                                             input logic [PW-1:0] y);
    logic signed [EW-1:0] d;
    d = $signed({1'b0, x}) - $signed({1'b0, y});
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

  // exact == 0 with a nonzero result falls out naturally: lhs > 0 == rhs.
  function automatic logic is_outlier(input logic [EW-1:0] e,
                                      input logic [PW-1:0] ex);
    logic [OW-1:0] lhs;
    logic [OW-1:0] rhs;
    lhs = OW'(e) * OW'(100);
    rhs = OW'(ex) * OW'(THR_PCT);
    return lhs > rhs;
  endfunction

  state_e state_q, state_d;

  logic [MAC_LAT-1:0]          dly_vld_q;
  logic [MAC_LAT-1:0][DW-1:0]  dly_a_q;
  logic [MAC_LAT-1:0][DW-1:0]  dly_b_q;

  logic [CNT_W-1:0] sample_cnt_q,  sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q,     err_cnt_d;
  logic [CNT_W-1:0] outlier_cnt_q, outlier_cnt_d;
  logic [SUM_W-1:0] err_sum_q,     err_sum_d;

  logic            start_acc;
  logic            stats_zero;
  logic            auto_stop;
  logic            cmp_vld;
  logic [DW-1:0]   cmp_a;
  logic [DW-1:0]   cmp_b;
  logic [PW-1:0]   exact;
  logic [EW-1:0]   err;
  logic            outl;

  // start is only accepted outside RUN and loses to a same-cycle stop.
  assign start_acc  = start_i && !stop_i && (state_q != RUN);
  assign stats_zero = clear_i || start_acc;

  // -------------------------------------------------------------------------
  // Issue stage -> delay line (valid is control, operands are data)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      dly_vld_q <= '0;
    end else begin
      dly_vld_q[0] <= mac.in_valid && (state_q == RUN);
      for (int i = 1; i < MAC_LAT; i++) begin
        dly_vld_q[i] <= dly_vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    dly_a_q[0] <= mac.dataa;
    dly_b_q[0] <= mac.datab;
    for (int i = 1; i < MAC_LAT; i++) begin
      dly_a_q[i] <= dly_a_q[i-1];
      dly_b_q[i] <= dly_b_q[i-1];
    end
  end

  // -------------------------------------------------------------------------
  // Compare stage: last delay stage meets adder_out of the same cycle
  // -------------------------------------------------------------------------
  assign cmp_vld = dly_vld_q[MAC_LAT-1];
  assign cmp_a   = dly_a_q[MAC_LAT-1];
  assign cmp_b   = dly_b_q[MAC_LAT-1];
  assign exact   = PW'(cmp_a) * PW'(cmp_b);
  assign err     = abs_diff(mac.adder_out, exact);
  assign outl    = is_outlier(err, exact);

  always_comb begin
    sample_cnt_d  = sample_cnt_q;
    err_cnt_d     = err_cnt_q;
    outlier_cnt_d = outlier_cnt_q;
    err_sum_d     = err_sum_q;
    if (stats_zero) begin
      sample_cnt_d  = '0;
      err_cnt_d     = '0;
      outlier_cnt_d = '0;
      err_sum_d     = '0;
    end else if (cmp_vld) begin
      sample_cnt_d = sat_inc(sample_cnt_q);
      if (err != '0) err_cnt_d     = sat_inc(err_cnt_q);
      if (outl)      outlier_cnt_d = sat_inc(outlier_cnt_q);
      err_sum_d = sat_add(err_sum_q, err);
    end
  end

  // Looking at the next count lets done rise the cycle after the final compare.
  assign auto_stop = (num_samples_i != '0) && (sample_cnt_d == num_samples_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (stop_i)       state_d = DONE;
        else if (start_i) state_d = RUN;
      end
      RUN: begin
        if (stop_i || auto_stop) state_d = DONE;
      end
      DONE: begin
        if (!stop_i && start_i) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Stats / FSM registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      state_q       <= IDLE;
      sample_cnt_q  <= '0;
      err_cnt_q     <= '0;
      outlier_cnt_q <= '0;
      err_sum_q     <= '0;
    end else begin
      state_q       <= state_d;
      sample_cnt_q  <= sample_cnt_d;
      err_cnt_q     <= err_cnt_d;
      outlier_cnt_q <= outlier_cnt_d;
      err_sum_q     <= err_sum_d;
    end
  end

  assign busy_o        = (state_q == RUN);
  assign done_o        = (state_q == DONE);
  assign sample_cnt_o  = sample_cnt_q;
  assign err_cnt_o     = err_cnt_q;
  assign outlier_cnt_o = outlier_cnt_q;
  assign err_sum_o     = err_sum_q;

`ifdef MAC_MON_MAXTRACK_EN
  logic [PW-1:0] max_err_q, max_err_d;
  logic [DW-1:0] max_a_q,   max_a_d;
  logic [DW-1:0] max_b_q,   max_b_d;

  // Strictly greater: a tie keeps the operands of the earlier sample.
  always_comb begin
    max_err_d = max_err_q;
    max_a_d   = max_a_q;
    max_b_d   = max_b_q;
    if (stats_zero) begin
      max_err_d = '0;
      max_a_d   = '0;
      max_b_d   = '0;
    end else if (cmp_vld && (err > {1'b0, max_err_q})) begin
      max_err_d = err[PW-1:0];
      max_a_d   = cmp_a;
      max_b_d   = cmp_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      max_err_q <= '0;
      max_a_q   <= '0;
      max_b_q   <= '0;
    end else begin
      max_err_q <= max_err_d;
      max_a_q   <= max_a_d;
      max_b_q   <= max_b_d;
    end
  end

  assign max_err_o = max_err_q;
  assign max_a_o   = max_a_q;
  assign max_b_o   = max_b_q;
`else
  assign max_err_o = '0;
  assign max_a_o   = '0;
  assign max_b_o   = '0;
`endif

endmodule

// File: tb/tb_mac_error_monitor.sv
module tb_mac_error_monitor;
  localparam int DW      = 8;
  localparam int MAC_LAT = 2;
  localparam int THR_PCT = 5;
  localparam int CNT_W   = 16;
  localparam int SUM_W   = 32;
  localparam longint CMAX = (longint'(1) << CNT_W) - 1;
  localparam longint SMAX = (longint'(1) << SUM_W) - 1;

  logic clk = 1'b0;
  logic aclr_n, start, stop, clear;
  logic [CNT_W-1:0] num_samples;
  logic busy, done;
  logic [CNT_W-1:0] sample_cnt, err_cnt, outlier_cnt;
  logic [SUM_W-1:0] err_sum;
  logic [2*DW-1:0]  max_err;
  logic [DW-1:0]    max_a, max_b;

  mac_error_monitor_if #(.DW(DW)) mac ();

  mac_error_monitor #(
    .DW(DW), .MAC_LAT(MAC_LAT), .THR_PCT(THR_PCT), .CNT_W(CNT_W), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .aclr_n(aclr_n), .start_i(start), .stop_i(stop), .clear_i(clear),
    .num_samples_i(num_samples), .mac(mac), .busy_o(busy), .done_o(done),
    .sample_cnt_o(sample_cnt), .err_cnt_o(err_cnt), .outlier_cnt_o(outlier_cnt),
    .err_sum_o(err_sum), .max_err_o(max_err), .max_a_o(max_a), .max_b_o(max_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     due;
    longint samp, errc, outc, sum, maxe, maxa, maxb;
  } exp_t;

  exp_t   sbq[$];
  longint plan[int];
  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  bit     m_run;
  longint m_samp, m_errc, m_outc, m_sum, m_maxe, m_maxa, m_maxb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sat(input longint v, input longint m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_zero();
    m_samp = 0; m_errc = 0; m_outc = 0; m_sum = 0;
    m_maxe = 0; m_maxa = 0; m_maxb = 0;
  endtask

  // Reference: statistics after one more compared sample.
  task automatic model_sample(input int a, input int b, input longint res, input int due);
    longint ex, e;
    exp_t   x;
    ex = longint'(a) * longint'(b);
    e  = (res > ex) ? res - ex : ex - res;
    m_samp = sat(m_samp + 1, CMAX);
    if (e != 0) m_errc = sat(m_errc + 1, CMAX);
    if (e * 100 > ex * THR_PCT) m_outc = sat(m_outc + 1, CMAX);
    m_sum = sat(m_sum + e, SMAX);
`ifdef MAC_MON_MAXTRACK_EN
    if (e > m_maxe) begin m_maxe = e; m_maxa = a; m_maxb = b; end
`endif
    x.due = due; x.samp = m_samp; x.errc = m_errc; x.outc = m_outc; x.sum = m_sum;
    x.maxe = m_maxe; x.maxa = m_maxa; x.maxb = m_maxb;
    sbq.push_back(x);
  endtask

  task automatic chk_quiet(input string tag);
    check({tag, "_samp"},    sample_cnt,  m_samp);
    check({tag, "_errc"},    err_cnt,     m_errc);
    check({tag, "_outc"},    outlier_cnt, m_outc);
    check({tag, "_sum"},     err_sum,     m_sum);
    check({tag, "_max_err"}, max_err,     m_maxe);
    check({tag, "_max_a"},   max_a,       m_maxa);
    check({tag, "_max_b"},   max_b,       m_maxb);
  endtask

  // One clock: adder_out carries the planned result on compare cycles, noise otherwise.
  task automatic tick();
    if (plan.exists(cyc)) begin
      mac.adder_out = 16'(plan[cyc]);
      plan.delete(cyc);
    end else begin
      mac.adder_out = 16'($urandom);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      mac.in_valid = 1'b0;
      mac.dataa    = DW'($urandom);
      mac.datab    = DW'($urandom);
      tick();
    end
  endtask

  task automatic issue(input int a, input int b, input longint res);
    int t;
    t = cyc + MAC_LAT;
    if (!plan.exists(t)) plan[t] = res;
    mac.in_valid = 1'b1;
    mac.dataa    = DW'(a);
    mac.datab    = DW'(b);
    if (m_run) model_sample(a, b, plan[t], t + 1);
    tick();
    mac.in_valid = 1'b0;
  endtask

  // Scoreboard monitor: stats become visible the cycle after each compare.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        x = sbq.pop_front();
        if (x.due < cyc) begin
          check("sb_missed_due", 64'(cyc), 64'(x.due));
        end else begin
          check("sb_samp",    sample_cnt,  x.samp);
          check("sb_errc",    err_cnt,     x.errc);
          check("sb_outc",    outlier_cnt, x.outc);
          check("sb_sum",     err_sum,     x.sum);
          check("sb_max_err", max_err,     x.maxe);
          check("sb_max_a",   max_a,       x.maxa);
          check("sb_max_b",   max_b,       x.maxb);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, b, mode;
    longint ex, r;
    aclr_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; num_samples = '0;
    mac.in_valid = 1'b0; mac.dataa = '0; mac.datab = '0; mac.adder_out = '0;
    model_zero(); m_run = 1'b0;
    @(negedge clk);
    idle(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    chk_quiet("rst");

    // Exact MAC, auto-stop after 100 samples
    aclr_n = 1'b1; num_samples = 16'd100;
    start = 1'b1; tick(); start = 1'b0;
    model_zero(); m_run = 1'b1;
    check("start_busy", busy, 1);
    for (int i = 0; i < 100; i++) begin
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      issue(a, b, longint'(a * b));
    end
    idle(MAC_LAT - 1);
    check("pre_autostop_busy", busy, 1);
    check("pre_autostop_done", done, 0);
    idle(1);
    m_run = 1'b0;
    check("autostop_done", done, 1);
    check("autostop_busy", busy, 0);
    check("exact_samp", sample_cnt, 100);
    check("exact_errc", err_cnt, 0);
    check("exact_sum", err_sum, 0);
    check("exact_outc", outlier_cnt, 0);
    // operands offered while DONE must be ignored
    issue(9, 9, 0);
    idle(MAC_LAT + 1);
    chk_quiet("done_ignore");

    // Directed errors, then random approximate results
    num_samples = '0;
    start = 1'b1; tick(); start = 1'b0;
    model_zero(); m_run = 1'b1;
    chk_quiet("restart");
    issue(255, 1, 250);
    issue(10, 10, 110);
    issue(0, 7, 1);
    idle(MAC_LAT + 1);
    check("dir_errc", err_cnt, 3);
    check("dir_sum", err_sum, 16);
    check("dir_outc", outlier_cnt, 2);
    for (int i = 0; i < 200; i++) begin
      a = $urandom_range(0, 255); b = $urandom_range(0, 255);
      ex = longint'(a * b);
      mode = $urandom_range(0, 2);
      if (mode == 0) r = ex;
      else if (mode == 1) begin
        r = ex + longint'($urandom_range(0, 80)) - 40;
        if (r < 0) r = 0;
        if (r > 65535) r = 65535;
      end else r = longint'($urandom_range(0, 65535));
      issue(a, b, r);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(MAC_LAT + 1);
    chk_quiet("rand");

    // Latency alignment
    clear = 1'b1; tick(); clear = 1'b0;
    model_zero();
    chk_quiet("clear");
    issue(3, 4, 12); issue(5, 6, 30); issue(7, 8, 56);
    idle(MAC_LAT + 1);
    check("lat_aligned_errc", err_cnt, 0);
    plan[cyc + MAC_LAT]     = 0;
    plan[cyc + MAC_LAT + 1] = 12;
    plan[cyc + MAC_LAT + 2] = 30;
    issue(3, 4, 12); issue(5, 6, 30); issue(7, 8, 56);
    idle(MAC_LAT + 1);
    check("lat_shift_errc", err_cnt, 3);
    check("lat_shift_sum", err_sum, 56);

    // clear in the compare cycle outranks the sample update
    m_run = 1'b0;
    issue(20, 20, 0);
    idle(MAC_LAT - 1);
    clear = 1'b1; tick(); clear = 1'b0;
    model_zero(); m_run = 1'b1;
    chk_quiet("clear_vs_cmp");

    // stop one cycle after the last issue: sample still counted
    issue(200, 3, 601);
    stop = 1'b1; tick(); stop = 1'b0;
    m_run = 1'b0;
    idle(MAC_LAT);
    check("stop_done", done, 1);
    check("stop_sample_counted", sample_cnt, 1);
    chk_quiet("stop");

    // start+stop together while DONE
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("ss_done_done", done, 1);
    check("ss_done_busy", busy, 0);

    // reset mid-RUN discards in-flight samples
    start = 1'b1; tick(); start = 1'b0;
    model_zero(); m_run = 1'b1;
    issue(11, 12, 130); issue(13, 14, 100); issue(15, 16, 0);
    aclr_n = 1'b0;
    while (sbq.size() > 0 && sbq[$].due > cyc) void'(sbq.pop_back());
    tick();
    model_zero(); m_run = 1'b0;
    check("rst_run_busy", busy, 0);
    check("rst_run_done", done, 0);
    chk_quiet("rst_run");
    aclr_n = 1'b1;
    idle(MAC_LAT + 2);
    check("rst_flush_busy", busy, 0);
    chk_quiet("rst_flush");

    // start+stop together from IDLE
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("ss_idle_done", done, 1);

    // max tracking: errs 3, 9, 9
    start = 1'b1; tick(); start = 1'b0;
    model_zero(); m_run = 1'b1;
    issue(2, 3, 9); issue(4, 5, 29); issue(6, 2, 3);
    idle(MAC_LAT + 1);
`ifdef MAC_MON_MAXTRACK_EN
    check("max_err", max_err, 9);
    check("max_a", max_a, 4);
    check("max_b", max_b, 5);
`else
    check("max_err_tied", max_err, 0);
    check("max_a_tied", max_a, 0);
`endif

    // saturation: 70000 worst-case samples
    clear = 1'b1; tick(); clear = 1'b0;
    model_zero();
    for (int i = 0; i < 70000; i++) issue(255, 255, 0);
    idle(MAC_LAT + 1);
    check("sat_samp", sample_cnt, 65535);
    check("sat_errc", err_cnt, 65535);
    check("sat_outc", outlier_cnt, 65535);
    check("sat_sum", err_sum, SMAX);
    check("sat_busy", busy, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    m_run = 1'b0;
    idle(2);
    check("sb_empty", 64'(sbq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
